mny_accum: RTL

Credit accumulator and vend/change controller for the vending machine. It sits directly downstream of the money decoder and consumes the decoder's 4-bit deposit value ($1, $5 or $10) under a one-cycle valid strobe. It tracks the running credit, services product selections against a price, issues a vend pulse, and hands back change through a valid/acknowledge handshake.

---
 rtl/mny_pkg.sv | 18 +
 rtl/mny_accum.sv | 107 ++++++++++
 2 files changed

// File: rtl/mny_pkg.sv
// Shared definitions for the vending-machine money path: controller states,
// default credit sizing and the coin/note denominations the decoder emits.
package mny_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } mny_state_t;

  localparam int unsigned CREDIT_W_DEF   = 7;
  localparam int unsigned MAX_CREDIT_DEF = 99;

  localparam logic [3:0] DEP_ONE  = 4'd1;
  localparam logic [3:0] DEP_FIVE = 4'd5;
  localparam logic [3:0] DEP_TEN  = 4'd10;

endpackage

// File: rtl/mny_accum.sv
// Credit accumulator and vend/change controller. Tracks deposited credit,
// services selections against a price and returns change via valid/ack.
module mny_accum
  import mny_pkg::*;
#(
  parameter int unsigned CREDIT_W   = CREDIT_W_DEF,
  parameter int unsigned MAX_CREDIT = MAX_CREDIT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dep_valid,
  input  logic [3:0]          dep_amt,
  input  logic                sel_valid,
  input  logic [CREDIT_W-1:0] sel_price,
  input  logic                refund_req,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic                dep_reject,
  output logic                sel_reject,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                busy
);

  localparam logic [CREDIT_W:0] MAX_EXT = (CREDIT_W+1)'(MAX_CREDIT);

  // One extra bit of headroom so credit + deposit can never wrap.
  function automatic logic [CREDIT_W:0] credit_sum(input logic [CREDIT_W-1:0] c,
                                                   input logic [3:0]          amt);
    return {1'b0, c} + {{(CREDIT_W-3){1'b0}}, amt};
  endfunction

  mny_state_t          state;
  mny_state_t          state_nx;
  logic [CREDIT_W-1:0] credit_nx;
  logic                dep_reject_nx;
  logic                sel_reject_nx;
  logic                dep_hit;
  logic [CREDIT_W:0]   dep_sum;
  logic                sel_ok;

  assign dep_hit = dep_valid && (dep_amt != 4'd0);
  assign dep_sum = credit_sum(credit, dep_amt);
  assign sel_ok  = (sel_price != '0) && (credit >= sel_price);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      credit     <= '0;
      dep_reject <= 1'b0;
      sel_reject <= 1'b0;
    end else begin
      state      <= state_nx;
      credit     <= credit_nx;
      dep_reject <= dep_reject_nx;
      sel_reject <= sel_reject_nx;
    end
  end

  // In IDLE a deposit outranks a selection, which outranks a refund; the
  // losers are dropped without any reject pulse.
  always_comb begin
    state_nx      = state;
    credit_nx     = credit;
    dep_reject_nx = 1'b0;
    sel_reject_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (dep_hit) begin
          if (dep_sum <= MAX_EXT) credit_nx = dep_sum[CREDIT_W-1:0];
          else                    dep_reject_nx = 1'b1;
        end else if (sel_valid) begin
          if (sel_ok) begin
            credit_nx = credit - sel_price;
            state_nx  = VEND;
          end else begin
            sel_reject_nx = 1'b1;
          end
        end else if (refund_req && (credit != '0)) begin
          state_nx = CHANGE;
        end
      end
      VEND: begin
        dep_reject_nx = dep_hit;
        state_nx      = (credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        dep_reject_nx = dep_hit;
        if (change_ack) begin
          credit_nx = '0;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Remaining outputs decode straight from the state and credit registers.
  always_comb begin
    vend         = (state == VEND);
    change_valid = (state == CHANGE);
    busy         = (state != IDLE);
    change_amt   = (state == CHANGE) ? credit : '0;
  end

endmodule
